// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a classic 5-stage pipeline.
// Resolves three hazards, in priority order:
//   1. a data-memory access still in progress, which freezes the whole pipe
//   2. a taken branch in MEM, which flushes IF/ID, ID/EX and EX/MEM
//   3. a load-use dependency, which inserts one bubble
// A watchdog counts consecutive memory wait cycles. It drops into a sticky
// ERROR state, which only reset clears.
// Two saturating counters report stall cycles and flush cycles.

module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic             EXMEM_branch_i,
    input  logic             EXMEM_zero_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             dmem_ready_i,

    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IDEX_write_o,
    output logic             EXMEM_write_o,
    output logic             MEMWB_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_flush_o,
    output logic             EXMEM_flush_o,
    output logic             PC_src_o,
    output logic             timeout_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // The wait counter only needs to reach TIMEOUT-1. On that count the next
    // busy cycle trips the watchdog.
    localparam int unsigned       WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_mem_busy;
    logic w_br_taken;
    logic w_load_use;
    logic w_in_error;
    logic w_stall_evt;
    logic w_flush_evt;

    // Hazard conditions, evaluated on the current cycle's pipeline contents.
    // Register $0 is hard-wired to zero, so a load "into" it never creates
    // a dependency.
    assign w_mem_busy = (EXMEM_MemRead_i | EXMEM_MemWrite_i) & ~dmem_ready_i;
    assign w_br_taken = EXMEM_branch_i & EXMEM_zero_i;
    assign w_load_use = IDEX_MemRead_i & (IDEX_Rt_i != 5'd0) &
                        ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i));

    assign w_in_error = (r_state == ST_ERROR);

    // A stall is counted for a freeze, or for a load-use bubble that a
    // taken branch has not overridden.
    // A branch hidden behind a freeze is not counted here. It is counted in
    // the cycle the freeze releases, when it is finally acted on.
    assign w_stall_evt = ~w_in_error & (w_mem_busy | (w_load_use & ~w_br_taken));
    assign w_flush_evt = ~w_in_error & ~w_mem_busy & w_br_taken;

    // Control decode: ERROR > freeze > branch flush > load-use bubble > normal.
    // The decode looks only at the current state and inputs. This way a
    // freeze releases in the same cycle the memory reports ready.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // if-chain below can leave one unassigned and infer a latch.
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IDEX_write_o  = 1'b1;
        EXMEM_write_o = 1'b1;
        MEMWB_write_o = 1'b1;
        IFID_flush_o  = 1'b0;
        IDEX_flush_o  = 1'b0;
        EXMEM_flush_o = 1'b0;
        PC_src_o      = 1'b0;

        if (w_in_error || w_mem_busy) begin
            // Hold every stage in place; nothing advances.
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_write_o  = 1'b0;
            EXMEM_write_o = 1'b0;
            MEMWB_write_o = 1'b0;
        end else if (w_br_taken) begin
            // Redirect fetch and squash the three younger instructions.
            PC_src_o      = 1'b1;
            IFID_flush_o  = 1'b1;
            IDEX_flush_o  = 1'b1;
            EXMEM_flush_o = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID for one cycle and push a bubble into EX.
            // Next cycle the load has moved to MEM, so the hazard clears.
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_flush_o  = 1'b1;
        end
    end

    // Watchdog FSM: track consecutive memory wait cycles and latch the error.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples the values from before this edge.
        if (!rst_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_busy) begin
                        if (TIMEOUT <= 1) begin
                            r_state   <= ST_ERROR;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state    <= ST_MEM_WAIT;
                            r_wait_cnt <= WAIT_W'(1);
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_mem_busy) begin
                        if (r_wait_cnt >= WAIT_LAST) begin
                            r_state   <= ST_ERROR;
                            r_timeout <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                ST_ERROR: begin
                    // Only reset can leave this state.
                    r_state   <= ST_ERROR;
                    r_timeout <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters: they stop at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_o   = r_timeout;
    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    // Internal consistency properties.
    a_legal_state : assert property (@(posedge clk_i) disable iff (!rst_i)
        state_o != 2'd3);

    a_error_frozen : assert property (@(posedge clk_i) disable iff (!rst_i)
        (r_state == ST_ERROR) |-> !(PC_write_o | IFID_write_o | IDEX_write_o |
                                    EXMEM_write_o | MEMWB_write_o | PC_src_o));

    a_timeout_sticky : assert property (@(posedge clk_i) disable iff (!rst_i)
        r_timeout |=> r_timeout);

endmodule
